// File: rtl/edge_pkg.sv
// edge_pkg: shared channel state encoding and edge-mode constants for multi_edge_latch.
`default_nettype none

package edge_pkg;

   typedef enum logic [1:0] {
      ARM_LO  = 2'd0,
      ARM_HI  = 2'd1,
      LATCHED = 2'd2
   } ch_state_t;

   localparam logic [1:0] MODE_ANY  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_OFF  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/edge_channel.sv
// edge_channel: one armed/latched edge FSM with an optional input debounce filter.
// Optional feature: EDGE_DEBOUNCE_EN adds a per-channel stable-sample counter.
`default_nettype none

module edge_channel
   import edge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_level,
   input  logic [1:0] mode,
   input  logic       clear,
   output logic       active,
   output logic       latch_next
);

   logic      level;
   ch_state_t state;
   ch_state_t state_n;
   ch_state_t rearm;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
   end

`ifdef EDGE_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             filt;

   // The filtered level moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt <= in_level;
         cnt  <= '0;
      end else if (in_level != filt) begin
         if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt <= in_level;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   assign level = filt;
`else
   assign level = in_level;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= in_level ? ARM_HI : ARM_LO;
      end else begin
         state <= state_n;
      end
   end

   // A clear re-arms from the current level and suppresses any edge seen on the same sample.
   always_comb begin
      rearm   = level ? ARM_HI : ARM_LO;
      state_n = state;
      case (state)
         ARM_LO: begin
            if (clear) begin
               state_n = rearm;
            end else if (level) begin
               state_n = (mode == MODE_ANY || mode == MODE_RISE) ? LATCHED : ARM_HI;
            end
         end
         ARM_HI: begin
            if (clear) begin
               state_n = rearm;
            end else if (!level) begin
               state_n = (mode == MODE_ANY || mode == MODE_FALL) ? LATCHED : ARM_LO;
            end
         end
         LATCHED: begin
            state_n = clear ? rearm : LATCHED;
         end
         default: begin
            state_n = ARM_LO;
         end
      endcase
   end

   assign active     = (state == LATCHED);
   assign latch_next = (state_n == LATCHED);

endmodule

`default_nettype wire

// File: rtl/multi_edge_latch.sv
// multi_edge_latch: CHANNELS sticky edge flags with a global mode and a first-event index.
// Optional feature: EDGE_DEBOUNCE_EN enables per-channel input debouncing.
`default_nettype none

module multi_edge_latch
   import edge_pkg::*;
#(
   parameter int CHANNELS        = 5,
   parameter int IDX_W           = 3,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] in,
   input  logic [1:0]          mode,
   input  logic [CHANNELS-1:0] clear,
   output logic [CHANNELS-1:0] active,
   output logic                any_active,
   output logic [IDX_W-1:0]    first_idx
);

   logic [CHANNELS-1:0] latch_next;
   logic [IDX_W-1:0]    next_idx;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .in_level  (in[i]),
         .mode      (mode),
         .clear     (clear[i]),
         .active    (active[i]),
         .latch_next(latch_next[i])
      );
   end

   assign any_active = |active;

   // Scan high-to-low so the lowest latching channel wins.
   always_comb begin
      next_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (latch_next[i]) begin
            next_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         first_idx <= '0;
      end else if (!any_active && (|latch_next)) begin
         first_idx <= next_idx;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_edge_latch.sv
// tb_multi_edge_latch: directed and random checks of multi_edge_latch against a behavioural model.
`default_nettype none

module tb_multi_edge_latch;

   localparam int C  = 5;
   localparam int D  = 4;
`ifdef EDGE_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [C-1:0] in_v;
   logic [1:0]   mode;
   logic [C-1:0] clear;
   logic [C-1:0] active;
   logic         any_active;
   logic [2:0]   first_idx;

   int n_assert = 0;
   int n_fail   = 0;

   bit m_lat  [C];
   bit m_base [C];
   bit m_filt [C];
   int m_run  [C];
   int m_fidx;

   always #5 clk = ~clk;

   multi_edge_latch #(
      .CHANNELS       (C),
      .IDX_W          (3),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_v),
      .mode      (mode),
      .clear     (clear),
      .active    (active),
      .any_active(any_active),
      .first_idx (first_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: applied once per rising edge with the inputs held at that edge.
   task automatic model_edge();
      bit any_before = 1'b0;
      bit lvl, allow, found;
      for (int i = 0; i < C; i++) any_before |= m_lat[i];
      found = 1'b0;
      for (int i = 0; i < C; i++) begin
         if (reset) begin
            m_lat[i]  = 1'b0;
            m_base[i] = in_v[i];
            m_filt[i] = in_v[i];
            m_run[i]  = 0;
         end else begin
            lvl = DB ? m_filt[i] : in_v[i];
            if (clear[i]) begin
               m_lat[i]  = 1'b0;
               m_base[i] = lvl;
            end else if (!m_lat[i] && lvl != m_base[i]) begin
               allow = (mode == 2'b00) || (mode == 2'b01 && lvl) || (mode == 2'b10 && !lvl);
               if (allow) begin
                  m_lat[i] = 1'b1;
                  if (!any_before && !found) begin
                     m_fidx = i;
                     found  = 1'b1;
                  end
               end else begin
                  m_base[i] = lvl;
               end
            end
            if (in_v[i] != m_filt[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin
                  m_filt[i] = in_v[i];
                  m_run[i]  = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      if (reset) m_fidx = 0;
   endtask

   task automatic step(input string tag);
      logic [C-1:0] exp_act;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      exp_act = '0;
      for (int i = 0; i < C; i++) exp_act[i] = m_lat[i];
      chk({tag, ".active"}, 32'(active), 32'(exp_act));
      chk({tag, ".any"}, 32'(any_active), 32'(|exp_act));
      chk({tag, ".idx"}, 32'(first_idx), 32'(m_fidx));
      clear = '0;
   endtask

   initial begin
      reset = 1'b1;
      in_v  = 5'b00101;
      mode  = 2'b00;
      clear = '0;
      @(negedge clk);

      // Reset holds all flags low while the channels baseline.
      for (int k = 0; k < 3; k++) step("rst");
      chk("rst_act", 32'(active), 32'd0);
      reset = 1'b0;
      step("rel");
      chk("rel_act", 32'(active), 32'd0);
      chk("rel_idx", 32'(first_idx), 32'd0);

`ifdef EDGE_DEBOUNCE_EN
      in_v = 5'b00111;
      for (int k = 0; k < 3; k++) step("db_pulse");
      in_v = 5'b00101;
      step("db_pulse_end");
      chk("db_no_latch", 32'(active[1]), 32'd0);
      in_v = 5'b00111;
      for (int k = 0; k < 4; k++) begin
         step("db_hold");
         chk("db_not_yet", 32'(active[1]), 32'd0);
      end
      step("db_hold5");
      chk("db_latch", 32'(active[1]), 32'd1);
      clear = 5'b11111;
      step("db_clr");
`endif

      // Rising mode: a fall re-baselines, the following rise latches.
      mode = 2'b01;
      in_v = 5'b00001; step("t2_fall");
      in_v = 5'b00101; step("t2_rise");
`ifndef EDGE_DEBOUNCE_EN
      chk("t2_act", 32'(active), 32'b00100);
      chk("t2_idx", 32'(first_idx), 32'd2);
`endif
      in_v = 5'b00001; step("t2_hold");
`ifndef EDGE_DEBOUNCE_EN
      chk("t2_sticky", 32'(active), 32'b00100);
`endif
      clear = 5'b11111; step("t2_clr");

      // Falling mode: simultaneous falls report the lower index.
      mode = 2'b10;
      in_v = 5'b01001; step("t3_rise");
      in_v = 5'b00000; step("t3_fall");
`ifndef EDGE_DEBOUNCE_EN
      chk("t3_act", 32'(active), 32'b01001);
      chk("t3_idx", 32'(first_idx), 32'd0);
`endif
      clear = 5'b00001; step("t3_clr0");
`ifndef EDGE_DEBOUNCE_EN
      chk("t3_act2", 32'(active), 32'b01000);
      chk("t3_idx2", 32'(first_idx), 32'd0);
`endif
      clear = 5'b01000; step("t3_clr3");

      // Clear beats a same-cycle edge.
      mode = 2'b00;
      in_v = 5'b00010; step("t4_latch");
      clear = 5'b00010; in_v = 5'b00000; step("t4_clr_edge");
`ifndef EDGE_DEBOUNCE_EN
      chk("t4_cleared", 32'(active), 32'd0);
`endif
      step("t4_idle");
`ifndef EDGE_DEBOUNCE_EN
      chk("t4_no_relatch", 32'(active), 32'd0);
`endif
      in_v = 5'b00010; step("t4_relatch");
      clear = 5'b11111; step("t4_clr");

      // Disabled mode ignores everything; then any-change picks up channel 4.
      mode = 2'b11;
      in_v = 5'b11101; step("t5_tog1");
      in_v = 5'b00010; step("t5_tog2");
`ifndef EDGE_DEBOUNCE_EN
      chk("t5_off", 32'(active), 32'd0);
`endif
      mode = 2'b00;
      in_v = 5'b10010; step("t5_any");
`ifndef EDGE_DEBOUNCE_EN
      chk("t5_act", 32'(active), 32'b10000);
      chk("t5_idx", 32'(first_idx), 32'd4);
`endif

      // Mid-operation reset drops every flag.
      reset = 1'b1; step("mid_rst");
      chk("mid_rst_act", 32'(active), 32'd0);
      reset = 1'b0; step("mid_rel");

      for (int k = 0; k < 400; k++) begin
         in_v = (($urandom % 3) == 0) ? C'($urandom) : in_v;
         if (($urandom % 16) == 0) mode = 2'($urandom);
         for (int i = 0; i < C; i++) clear[i] = (($urandom % 10) == 0);
         reset = (($urandom % 97) == 0);
         step("rand");
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
